// File: rtl/flags_stack_if.sv
// flags_stack_if: groups the interrupt/RTI sequencer handshake and the
// flags-register restore path of the flags_stack block.
// The master modport is the sequencer/flags-register side.
// The slave modport is the stack itself.
interface flags_stack_if #(
   parameter int PTR_W = 3
);
   logic             push;
   logic             pop;
   logic [2:0]       flags_in;
   logic             err_clr;
   logic [2:0]       flags_out;
   logic             restore_en;
   logic [PTR_W:0]   count;
   logic             empty;
   logic             full;
   logic             ovf_err;
   logic             udf_err;

   modport master (
      output push, pop, flags_in, err_clr,
      input  flags_out, restore_en, count, empty, full, ovf_err, udf_err
   );

   modport slave (
      input  push, pop, flags_in, err_clr,
      output flags_out, restore_en, count, empty, full, ovf_err, udf_err
   );
endinterface

// File: rtl/flags_stack.sv
// flags_stack: LIFO of {Z,V,N} condition-flag frames for nested interrupts.
// A push saves the live flags on interrupt entry. A pop restores the top
// frame to the flags register through flags_out, qualified by a one-cycle
// restore_en strobe one clock after the pop.
// Optional feature macro: FLAGS_STACK_ERR_EN makes ovf_err/udf_err sticky
// error flags cleared by err_clr. Without it both are tied low.
module flags_stack #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input logic          clk,
   input logic          rst,
   flags_stack_if.slave bus
);

   localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);

   logic [2:0]       r_mem [DEPTH];
   logic [PTR_W:0]   r_sp;
   logic             r_empty;
   logic             r_full;
   logic [2:0]       r_flagsOut;
   logic             r_restoreEn;

   logic             w_popOk;
   logic             w_swap;
   logic             w_pushOk;
   logic             w_popOnly;
   logic             w_ovfEvent;
   logic             w_udfEvent;
   logic [PTR_W:0]   w_spTop;
   logic [PTR_W-1:0] w_topIdx;
   logic [PTR_W-1:0] w_spIdx;
   logic [PTR_W:0]   w_spNext;

   // Decode the request into exactly one stack action.
   // A pop is honoured whenever the stack holds data. A push alongside an
   // honoured pop becomes a swap, so a full stack never blocks it.
   // A plain push is dropped when full.
   always_comb begin
      w_popOk    = bus.pop && !r_empty;
      w_swap     = bus.push && w_popOk;
      w_pushOk   = bus.push && !w_popOk && !r_full;
      w_popOnly  = w_popOk && !bus.push;
      w_ovfEvent = bus.push && !w_popOk && r_full;
      w_udfEvent = bus.pop && r_empty;
      w_spTop    = r_sp - 1'b1;
      w_topIdx   = w_spTop[PTR_W-1:0];
      w_spIdx    = r_sp[PTR_W-1:0];
      w_spNext   = r_sp;
      if (w_pushOk) begin
         w_spNext = r_sp + 1'b1;
      end else if (w_popOnly) begin
         w_spNext = w_spTop;
      end
   end

   // Frame storage. The array is never reset because entries at or above
   // sp are never read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_pushOk) begin
            r_mem[w_spIdx] <= bus.flags_in;
         end else if (w_swap) begin
            r_mem[w_topIdx] <= bus.flags_in;
         end
      end
   end

   // Stack pointer and the registered occupancy flags derived from its next value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sp    <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
      end else begin
         r_sp    <= w_spNext;
         r_empty <= (w_spNext == '0);
         r_full  <= (w_spNext == LP_DEPTH);
      end
   end

   // Restore path. The old top entry is captured at the pop edge. During a
   // swap this read sees the entry before it is overwritten. flags_out holds
   // its value between strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flagsOut  <= 3'b000;
         r_restoreEn <= 1'b0;
      end else begin
         r_restoreEn <= w_popOk;
         if (w_popOk) begin
            r_flagsOut <= r_mem[w_topIdx];
         end
      end
   end

`ifdef FLAGS_STACK_ERR_EN
   logic r_ovfErr;
   logic r_udfErr;

   // Sticky error flags. A new event wins over a simultaneous err_clr, so
   // the event is never lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovfErr <= 1'b0;
         r_udfErr <= 1'b0;
      end else begin
         if (w_ovfEvent) begin
            r_ovfErr <= 1'b1;
         end else if (bus.err_clr) begin
            r_ovfErr <= 1'b0;
         end
         if (w_udfEvent) begin
            r_udfErr <= 1'b1;
         end else if (bus.err_clr) begin
            r_udfErr <= 1'b0;
         end
      end
   end

   assign bus.ovf_err = r_ovfErr;
   assign bus.udf_err = r_udfErr;
`else
   // Without error reporting, bad pushes and pops are simply dropped.
   logic w_unusedErr;
   assign w_unusedErr = &{1'b0, bus.err_clr, w_ovfEvent, w_udfEvent};
   assign bus.ovf_err = 1'b0;
   assign bus.udf_err = 1'b0;
`endif

   assign bus.flags_out  = r_flagsOut;
   assign bus.restore_en = r_restoreEn;
   assign bus.count      = r_sp;
   assign bus.empty      = r_empty;
   assign bus.full       = r_full;

endmodule

// File: tb/tb_flags_stack.sv
// tb_flags_stack: directed bench for flags_stack with a reference stack
// model and a scoreboard of expected restore values.
// Honours FLAGS_STACK_ERR_EN for the expected error-flag behaviour.
module tb_flags_stack;

   localparam int DEPTH = 8;
   localparam int PTR_W = 3;

   logic clk;
   logic rst;

   flags_stack_if #(.PTR_W(PTR_W)) bus ();

   flags_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [2:0] modelStack[$];
   logic [2:0] sbQueue[$];
   logic [2:0] mFlags;
   logic       mRestore;
   logic       mOvf;
   logic       mUdf;

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the reference model at the edge,
   // then check every output at the following falling edge.
   task automatic applyStimulus(input logic r, input logic pu, input logic po,
                                input logic [2:0] fin, input logic clr);
      logic popOk;
      logic ovfEv;
      logic udfEv;
      rst         = r;
      bus.push    = pu;
      bus.pop     = po;
      bus.flags_in = fin;
      bus.err_clr = clr;
      @(posedge clk);
      if (r) begin
         modelStack.delete();
         sbQueue.delete();
         mFlags   = 3'b000;
         mRestore = 1'b0;
         mOvf     = 1'b0;
         mUdf     = 1'b0;
      end else begin
         popOk = po && (modelStack.size() > 0);
         ovfEv = 1'b0;
         udfEv = po && !popOk;
         mRestore = popOk;
         if (popOk) begin
            mFlags = modelStack.pop_back();
            sbQueue.push_back(mFlags);
            if (pu) modelStack.push_back(fin);
         end else if (pu) begin
            if (modelStack.size() < DEPTH) modelStack.push_back(fin);
            else ovfEv = 1'b1;
         end
`ifdef FLAGS_STACK_ERR_EN
         if (ovfEv) mOvf = 1'b1;
         else if (clr) mOvf = 1'b0;
         if (udfEv) mUdf = 1'b1;
         else if (clr) mUdf = 1'b0;
`else
         mOvf = 1'b0;
         mUdf = 1'b0;
`endif
      end
      @(negedge clk);
      checkOutput("restore_en", 8'(bus.restore_en), 8'(mRestore));
      checkOutput("flags_out", 8'(bus.flags_out), 8'(mFlags));
      checkOutput("count", 8'(bus.count), 8'(modelStack.size()));
      checkOutput("empty", 8'(bus.empty), 8'(modelStack.size() == 0));
      checkOutput("full", 8'(bus.full), 8'(modelStack.size() == DEPTH));
      checkOutput("ovf_err", 8'(bus.ovf_err), 8'(mOvf));
      checkOutput("udf_err", 8'(bus.udf_err), 8'(mUdf));
      if (bus.restore_en === 1'b1) begin
         if (sbQueue.size() > 0) begin
            checkOutput("sb_restore", 8'(bus.flags_out), 8'(sbQueue.pop_front()));
         end else begin
            checkOutput("sb_unexpected_restore", 8'(1), 8'(0));
         end
      end
      if (bus.restore_en === 1'b1) begin
         checkOutput("never_111", 8'(bus.flags_out == 3'b111 && mFlags != 3'b111), 8'(0));
      end
   endtask

   initial begin
      logic [2:0] vals [8];
      vals = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b010};
      rst = 1'b1;
      bus.push = 1'b0;
      bus.pop = 1'b0;
      bus.flags_in = 3'b000;
      bus.err_clr = 1'b0;
      modelStack.delete();
      mFlags = 3'b000;
      mRestore = 1'b0;
      mOvf = 1'b0;
      mUdf = 1'b0;
      @(negedge clk);

      $display("[TB] reset and idle");
      applyStimulus(1, 0, 0, 3'b000, 0);
      applyStimulus(1, 0, 0, 3'b000, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 3'b000, 0);
      checkOutput("idle_count_const", 8'(bus.count), 8'd0);

      $display("[TB] three pushes, three pops");
      applyStimulus(0, 1, 0, 3'b100, 0);
      applyStimulus(0, 1, 0, 3'b010, 0);
      applyStimulus(0, 1, 0, 3'b001, 0);
      applyStimulus(0, 0, 1, 3'b000, 0);
      checkOutput("lifo_first_const", 8'(bus.flags_out), 8'(3'b001));
      applyStimulus(0, 0, 1, 3'b000, 0);
      checkOutput("lifo_second_const", 8'(bus.flags_out), 8'(3'b010));
      applyStimulus(0, 0, 1, 3'b000, 0);
      checkOutput("lifo_third_const", 8'(bus.flags_out), 8'(3'b100));
      applyStimulus(0, 0, 0, 3'b000, 0);
      checkOutput("hold_flags_const", 8'(bus.flags_out), 8'(3'b100));

      $display("[TB] fill, overflow, drain");
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, vals[i], 0);
      checkOutput("full_const", 8'(bus.full), 8'd1);
      applyStimulus(0, 1, 0, 3'b111, 0);
      checkOutput("ovf_count_const", 8'(bus.count), 8'd8);
      applyStimulus(0, 1, 0, 3'b111, 1);
      applyStimulus(0, 1, 1, 3'b011, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 3'b000, 0);
      applyStimulus(0, 0, 0, 3'b000, 1);

      $display("[TB] underflow and clear");
      applyStimulus(0, 0, 1, 3'b000, 0);
      applyStimulus(0, 0, 0, 3'b000, 0);
      applyStimulus(0, 0, 0, 3'b000, 1);
      applyStimulus(0, 1, 1, 3'b110, 0);
      applyStimulus(0, 0, 1, 3'b000, 1);
      applyStimulus(0, 0, 0, 3'b000, 1);

      $display("[TB] swap");
      applyStimulus(0, 1, 0, 3'b011, 0);
      applyStimulus(0, 1, 0, 3'b010, 0);
      applyStimulus(0, 1, 1, 3'b101, 0);
      checkOutput("swap_flags_const", 8'(bus.flags_out), 8'(3'b010));
      checkOutput("swap_count_const", 8'(bus.count), 8'd2);
      applyStimulus(0, 0, 1, 3'b000, 0);
      checkOutput("after_swap_const", 8'(bus.flags_out), 8'(3'b101));
      applyStimulus(0, 0, 1, 3'b000, 0);
      applyStimulus(0, 0, 0, 3'b000, 0);

      $display("[TB] reset cancels pending restore");
      applyStimulus(0, 1, 0, 3'b110, 0);
      applyStimulus(0, 0, 1, 3'b000, 0);
      applyStimulus(0, 0, 1, 3'b000, 0);
      applyStimulus(1, 1, 1, 3'b111, 0);
      checkOutput("rst_restore_const", 8'(bus.restore_en), 8'd0);
      checkOutput("rst_flags_const", 8'(bus.flags_out), 8'd0);
      applyStimulus(0, 0, 0, 3'b000, 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 200; i++) begin
         applyStimulus(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                       $urandom_range(0, 3) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
